// File: rtl/rede_out_collect.sv
// Collects one signed word per processor output port into a frame, optionally finds the
// largest slot (argmax), then holds the frame until the consumer accepts it. Option macro: REDE_OUT_ARGMAX_EN.
module rede_out_collect #(
  parameter int NUBITS = 31,
  parameter int NUOUT  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUBITS-1:0]          io_out,
  input  logic [NUOUT-1:0]           out_en,
  output logic [NUOUT*NUBITS-1:0]    frm_data,
  output logic                       frm_valid,
  input  logic                       frm_ready,
  output logic [$clog2(NUOUT)-1:0]   cls_idx,
  output logic [NUBITS-1:0]          cls_max,
  output logic                       ovr,
  output logic                       busy
);

  localparam int IW = $clog2(NUOUT);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCAN    = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [NUOUT*NUBITS-1:0]   r_frm;
  logic [NUOUT-1:0]          r_mask;
  logic [NUOUT-1:0]          w_mask_nxt;
  logic                      r_ovr;
  logic                      w_ovr_set;
  logic                      w_cap;
  logic                      w_any;
  logic                      w_multi;
  logic [IW-1:0]             w_sel;

  assign w_any   = |out_en;
  assign w_multi = (out_en & (out_en - NUOUT'(1))) != '0;

  // Priority pick of the lowest set strobe bit.
  always_comb begin
    w_sel = '0;
    for (int unsigned i = NUOUT; i > 0; i--) begin
      if (out_en[i-1]) w_sel = IW'(i - 1);
    end
  end

`ifdef REDE_OUT_ARGMAX_EN
  logic [IW-1:0]             r_scan_i;
  logic [IW-1:0]             r_idx;
  logic signed [NUBITS-1:0]  r_max;
  logic signed [NUBITS-1:0]  w_cand;
  logic signed [NUBITS-1:0]  w_base_max;
  logic [IW-1:0]             w_base_idx;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_cap       = 1'b0;
    w_ovr_set   = 1'b0;
    case (r_state)
      COLLECT: begin
        if (w_any) begin
          w_cap      = 1'b1;
          w_mask_nxt = r_mask | (NUOUT'(1) << w_sel);
          if (w_multi || r_mask[w_sel]) w_ovr_set = 1'b1;
        end
        // Leave on the edge after the mask filled; a capture on that edge still lands.
        if (&r_mask) begin
`ifdef REDE_OUT_ARGMAX_EN
          w_state_nxt = SCAN;
`else
          w_state_nxt = HOLD;
`endif
        end
      end
`ifdef REDE_OUT_ARGMAX_EN
      SCAN: begin
        if (w_any) w_ovr_set = 1'b1;
        if (r_scan_i == IW'(NUOUT - 1)) w_state_nxt = HOLD;
      end
`endif
      HOLD: begin
        if (w_any) w_ovr_set = 1'b1;
        if (frm_ready) begin
          w_state_nxt = COLLECT;
          w_mask_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = COLLECT;
        w_mask_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= COLLECT;
      r_mask  <= '0;
      r_ovr   <= 1'b0;
      r_frm   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      if (w_ovr_set) r_ovr <= 1'b1;
      if (w_cap) r_frm[w_sel*NUBITS +: NUBITS] <= io_out;
    end
  end

`ifdef REDE_OUT_ARGMAX_EN
  // First scan step seeds the running max from slot 0, so no separate init cycle is needed.
  always_comb begin
    w_cand     = $signed(r_frm[r_scan_i*NUBITS +: NUBITS]);
    w_base_max = (r_scan_i == IW'(1)) ? $signed(r_frm[NUBITS-1:0]) : r_max;
    w_base_idx = (r_scan_i == IW'(1)) ? '0 : r_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_i <= '0;
      r_idx    <= '0;
      r_max    <= '0;
    end else if (r_state == COLLECT) begin
      r_scan_i <= IW'(1);
    end else if (r_state == SCAN) begin
      r_scan_i <= r_scan_i + IW'(1);
      if (w_cand > w_base_max) begin
        r_max <= w_cand;
        r_idx <= r_scan_i;
      end else begin
        r_max <= w_base_max;
        r_idx <= w_base_idx;
      end
    end
  end

  assign cls_idx = r_idx;
  assign cls_max = r_max;
`else
  assign cls_idx = '0;
  assign cls_max = '0;
`endif

  assign frm_data  = r_frm;
  assign frm_valid = (r_state == HOLD);
  assign busy      = (r_state != COLLECT);
  assign ovr       = r_ovr;

endmodule

// File: doc/rede_out_collect.md
REDE_OUT_COLLECT -- requirements
Module: rede_out_collect

Interface
REQ-001 SHALL have parameter NUBITS, default 31: width of one signed output word.
REQ-002 SHALL have parameter NUOUT, default 4: number of processor output ports, a power of two of at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port io_out, input, NUBITS bits: signed data word from the processor.
REQ-006 SHALL have port out_en, input, NUOUT bits: decoded per-port write strobe; bit k marks io_out as the port-k word.
REQ-007 SHALL have port frm_data, output, NUOUT*NUBITS bits: captured frame; slot k occupies bits [k*NUBITS +: NUBITS].
REQ-008 SHALL have port frm_valid, output, 1 bit: frame complete and held.
REQ-009 SHALL have port frm_ready, input, 1 bit: consumer accepts the frame.
REQ-010 SHALL have port cls_idx, output, log2(NUOUT) bits: index of the largest slot.
REQ-011 SHALL have port cls_max, output, NUBITS bits: signed value of the largest slot.
REQ-012 SHALL have port ovr, output, 1 bit: sticky error flag for lost or overwritten data.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than COLLECT.

Function
REQ-014 SHALL implement the states COLLECT, SCAN and HOLD.
REQ-015 In COLLECT, SHALL write io_out to slot k and set mask bit k at the edge where out_en[k]=1.
REQ-016 If more than one out_en bit is set, SHALL capture the lowest-index bit only and set ovr.
REQ-017 If a slot whose mask bit is already set is captured again in COLLECT, SHALL overwrite that slot and set ovr.
REQ-018 SHALL go COLLECT->SCAN on the edge after the mask becomes all ones; the final capture happens at edge t.
REQ-019 In SCAN, SHALL compare one slot i per cycle, i = 1..NUOUT-1, starting from max=slot0 and idx=0.
REQ-020 SCAN comparisons SHALL be signed; max and idx update only on strictly greater, so ties keep the lower index.
REQ-021 SHALL go SCAN->HOLD after the last comparison; frm_valid rises at edge t+NUOUT (t+4 for the defaults).
REQ-022 In HOLD, SHALL keep frm_data, cls_idx and cls_max stable while frm_valid=1.
REQ-023 On frm_valid&&frm_ready, SHALL clear the mask and return to COLLECT at the next edge; frm_valid falls at that edge.
REQ-024 Any out_en bit set while in SCAN or HOLD SHALL be dropped and SHALL set ovr; this includes the handshake cycle.
REQ-025 frm_ready SHALL be ignored outside HOLD.
REQ-026 Back-to-back frames SHALL be sustained; a capture one cycle after the handshake edge is accepted.
REQ-027 ovr SHALL be cleared only by rst.

Reset
REQ-028 While rst=1, regardless of clk, SHALL force state=COLLECT, mask=0, frm_valid=0, busy=0, ovr=0, cls_idx=0, cls_max=0, frm_data=0.
REQ-029 Reset asserted mid-frame or in HOLD SHALL discard the partial or held frame without emitting it.
REQ-030 SHALL accept captures on the first rising edge after rst deasserts.

Configuration
REQ-031 Macro REDE_OUT_ARGMAX_EN SHALL select whether the SCAN stage is built.
REQ-032 With REDE_OUT_ARGMAX_EN defined, SHALL implement SCAN and the argmax outputs per REQ-019..REQ-021.
REQ-033 Without REDE_OUT_ARGMAX_EN, SHALL omit SCAN and go COLLECT->HOLD, so frm_valid rises at edge t+1.
REQ-034 Without REDE_OUT_ARGMAX_EN, cls_idx and cls_max SHALL be constant 0; all other behaviour is unchanged.

Verification
REQ-035 Scenario: capture ports 0..3 with values 5, -7, 12, 3 on consecutive cycles, frm_ready=1 -> frm_valid 4 cycles after the port-3 capture, cls_idx=2, cls_max=12, frm_data slots match, ovr=0.
REQ-036 Scenario: all-negative values -9, -2, -2, -30 -> cls_idx=1 (tie keeps lower index), cls_max=-2.
REQ-037 Scenario: port 1 captured twice (10 then 20) before the frame completes -> slot1=20, ovr=1, frame still emitted.
REQ-038 Scenario: hold frm_ready=0 for 10 cycles in HOLD and pulse out_en=4'b0001 meanwhile -> outputs stable, data dropped, ovr=1; frm_ready=1 -> COLLECT on the next edge.
REQ-039 Scenario: assert rst after 2 of 4 captures, then deassert and capture 4 new values -> only the new frame is emitted, no stale slots, ovr=0.
REQ-040 Scenario: build without REDE_OUT_ARGMAX_EN -> frm_valid 1 cycle after the last capture, cls_idx=0, cls_max=0.
